// File: rtl/dac_sample_buf.sv
`default_nettype none
// ============================================================================
//  Module      : dac_sample_buf
//  Description : Asymmetric simple-dual-port sample RAM for the audio DAC path.
//                Byte-wide write port on the MCU side and a 32-bit registered
//                read port on the DAC side. The read word is {left, right}
//                and the byte lanes are little-endian. Both ports share a
//                single clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_sample_buf #(
  parameter int ADDR_A_W = 11,            // byte address width (write side)
  parameter int ADDR_B_W = ADDR_A_W - 2   // word address width (read side)
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                wea,
  input  logic [ADDR_A_W-1:0] addra,
  input  logic [7:0]          dina,
  input  logic [ADDR_B_W-1:0] addrb,
  output logic [31:0]         doutb
);

  localparam int c_DEPTH = 2 ** ADDR_B_W;
  localparam int c_LANES = 4;

  // Storage is organised as 32-bit words with per-byte write enables so it
  // maps onto a byte-enabled block RAM rather than a byte-wide array.
  logic [31:0]         mem_q [c_DEPTH];
  logic [31:0]         dout_q;
  logic [31:0]         dout_d;

  logic [ADDR_B_W-1:0] wr_word_d;
  logic [c_LANES-1:0]  wr_be_d;

  // Split the byte address into a word index and a one-hot byte-lane enable.
  always_comb begin
    wr_word_d = addra[ADDR_A_W-1:2];
    wr_be_d   = '0;
    if (wea) begin
      wr_be_d = 4'b0001 << addra[1:0];
    end
  end

  // Byte-lane writes; independent of reset so the MCU can preload while
  // the DAC side is held in reset.
  always_ff @(posedge clkin) begin
    for (int l = 0; l < c_LANES; l++) begin
      if (wr_be_d[l]) begin
        mem_q[wr_word_d][l*8 +: 8] <= dina;
      end
    end
  end

  // Read data selection: reset forces zero, otherwise the addressed word.
  // The array read sees the pre-edge contents, giving read-first behaviour
  // when a write hits the same word on the same edge.
  always_comb begin
    dout_d = mem_q[addrb];
    if (reset) begin
      dout_d = 32'h0;
    end
  end

  // Registered read port (the block RAM output register).
  always_ff @(posedge clkin) begin
    dout_q <= dout_d;
  end

  assign doutb = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_sample_buf
//  Description : Scoreboard bench for dac_sample_buf. The driver pushes the
//                expected read word for every clock; a monitor pops and
//                compares it against doutb just after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_sample_buf;

  logic        clkin;
  logic        reset;
  logic        wea;
  logic [10:0] addra;
  logic [7:0]  dina;
  logic [8:0]  addrb;
  logic [31:0] doutb;

  dac_sample_buf #(
    .ADDR_A_W(11),
    .ADDR_B_W(9)
  ) u_dut (
    .clkin (clkin),
    .reset (reset),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .addrb (addrb),
    .doutb (doutb)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  typedef struct packed {
    logic        chk;
    logic [31:0] exp;
    logic [7:0]  id;
  } sb_entry_t;

  sb_entry_t   sb_q [$];
  logic [7:0]  mdl [0:2047];
  int          n_pass;
  int          n_total;

  // One clock of stimulus. The expected word is either the hand-computed
  // constant (directed tests) or the byte-array model (bulk tests).
  task automatic step(input logic r, input logic w, input logic [10:0] a,
                      input logic [7:0] d, input logic [8:0] b, input logic chk,
                      input logic use_k, input logic [31:0] k, input logic [7:0] id);
    sb_entry_t e;
    @(negedge clkin);
    reset = r; wea = w; addra = a; dina = d; addrb = b;
    @(posedge clkin);
    e.chk = chk;
    e.id  = id;
    if (r) e.exp = 32'h0;
    else   e.exp = {mdl[{b, 2'd3}], mdl[{b, 2'd2}], mdl[{b, 2'd1}], mdl[{b, 2'd0}]};
    if (use_k) e.exp = k;
    if (w) mdl[a] = d;
    sb_q.push_back(e);
  endtask

  // Monitor: the read port presents a new word after every edge.
  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clkin);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk) begin
          n_total++;
          if (doutb === e.exp) n_pass++;
          else $display("FAIL t%0d doutb got=%08h expected=%08h at %0t", e.id, doutb, e.exp, $time);
        end
      end
    end
  end

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; wea = 1'b0; addra = '0; dina = '0; addrb = '0;
    for (int i = 0; i < 2048; i++) mdl[i] = 8'h00;

    // Bring storage to a known all-zero state under reset.
    for (int i = 0; i < 2048; i++) step(1'b1, 1'b1, 11'(i), 8'h00, 9'h0, 1'b0, 1'b0, 32'h0, 8'd0);

    // 1: reset hold with toggling addrb, write during reset, first real read.
    step(1'b1, 1'b0, 11'h000, 8'h00, 9'h155, 1'b1, 1'b1, 32'h0, 8'd1);
    step(1'b1, 1'b1, 11'h000, 8'hAA, 9'h0AA, 1'b1, 1'b1, 32'h0, 8'd1);
    step(1'b1, 1'b0, 11'h000, 8'h00, 9'h000, 1'b1, 1'b1, 32'h0, 8'd1);
    step(1'b0, 1'b0, 11'h000, 8'h00, 9'h000, 1'b1, 1'b1, 32'h000000AA, 8'd1);

    // 2: lane order.
    step(1'b0, 1'b1, 11'h004, 8'h11, 9'h000, 1'b1, 1'b1, 32'h000000AA, 8'd2);
    step(1'b0, 1'b1, 11'h005, 8'h22, 9'h000, 1'b1, 1'b1, 32'h000000AA, 8'd2);
    step(1'b0, 1'b1, 11'h006, 8'h33, 9'h000, 1'b1, 1'b1, 32'h000000AA, 8'd2);
    step(1'b0, 1'b1, 11'h007, 8'h44, 9'h000, 1'b1, 1'b1, 32'h000000AA, 8'd2);
    step(1'b0, 1'b0, 11'h000, 8'h00, 9'h001, 1'b1, 1'b1, 32'h44332211, 8'd2);

    // 3: top word, no aliasing onto word 0.
    step(1'b0, 1'b1, 11'h7FC, 8'hDE, 9'h000, 1'b0, 1'b0, 32'h0, 8'd3);
    step(1'b0, 1'b1, 11'h7FD, 8'hAD, 9'h000, 1'b0, 1'b0, 32'h0, 8'd3);
    step(1'b0, 1'b1, 11'h7FE, 8'hBE, 9'h000, 1'b0, 1'b0, 32'h0, 8'd3);
    step(1'b0, 1'b1, 11'h7FF, 8'hEF, 9'h000, 1'b0, 1'b0, 32'h0, 8'd3);
    step(1'b0, 1'b0, 11'h000, 8'h00, 9'h1FF, 1'b1, 1'b1, 32'hEFBEADDE, 8'd3);
    step(1'b0, 1'b0, 11'h000, 8'h00, 9'h000, 1'b1, 1'b1, 32'h000000AA, 8'd3);

    // 4: read-first collision on word 2.
    step(1'b0, 1'b1, 11'h009, 8'h5A, 9'h002, 1'b1, 1'b1, 32'h00000000, 8'd4);
    step(1'b0, 1'b0, 11'h000, 8'h00, 9'h002, 1'b1, 1'b1, 32'h00005A00, 8'd4);

    // 5: no writes with random addra/dina, then stream every word.
    for (int i = 0; i < 100; i++)
      step(1'b0, 1'b0, 11'($urandom_range(0, 2047)), 8'($urandom_range(0, 255)),
           9'($urandom_range(0, 511)), 1'b1, 1'b0, 32'h0, 8'd5);
    for (int i = 0; i < 512; i++)
      step(1'b0, 1'b0, 11'h000, 8'h00, 9'(i), 1'b1, 1'b0, 32'h0, 8'd5);

    // 6: random traffic against the byte model, occasional reset cycles.
    for (int i = 0; i < 10000; i++)
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
           11'($urandom_range(0, 2047)), 8'($urandom_range(0, 255)),
           9'($urandom_range(0, 511)), 1'b1, 1'b0, 32'h0, 8'd6);

    // Drain the scoreboard; anything left over is a failure.
    repeat (3) @(posedge clkin);
    #2;
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain pending got=%0d expected=0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
